// File: rtl/ula_pkg.sv
// Shared opcodes and FSM state type for the multicycle ALU.
// Imported by the top and by the iterative mul/div datapath.
package ula_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_QUO  = 4'b0011;
  localparam logic [3:0] OP_REM  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    CALC   = 2'b01,
    FIM    = 2'b10
  } estado_t;

endpackage

// File: rtl/mult_div_iterativo.sv
// Shared accumulator/shift-register datapath: shift-add multiply
// and restoring divide, one step per cycle, N steps per operation.
module mult_div_iterativo
  import ula_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           step,
  input  logic           modo_div,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] produto,
  output logic [N-1:0]   quociente,
  output logic [N-1:0]   resto
);

  localparam int CW = $clog2(N) + 1;

  logic [N-1:0] acc, sr, opnd;
  logic [N-1:0] acc_nx, sr_nx;
  logic         div_q;
  logic [CW-1:0] cnt;
  logic [N:0]   soma, desl, dif;
  logic         cabe;

  // One step of either algorithm; values after the step are exposed
  // so the top can capture the final result on the last step edge.
  always_comb begin
    soma   = {1'b0, acc} + (sr[0] ? {1'b0, opnd} : '0);
    desl   = {acc, sr[N-1]};
    dif    = desl - {1'b0, opnd};
    cabe   = desl >= {1'b0, opnd};
    acc_nx = acc;
    sr_nx  = sr;
    if (div_q) begin
      acc_nx = cabe ? dif[N-1:0] : desl[N-1:0];
      sr_nx  = {sr[N-2:0], cabe};
    end else begin
      acc_nx = soma[N:1];
      sr_nx  = {soma[0], sr[N-1:1]};
    end
  end

  assign done      = step && (cnt == CW'(N - 1));
  assign produto   = {acc_nx, sr_nx};
  assign quociente = sr_nx;
  assign resto     = acc_nx;

  // Load operands on start, advance one step per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      sr    <= '0;
      opnd  <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      acc   <= '0;
      sr    <= modo_div ? a : b;
      opnd  <= modo_div ? b : a;
      div_q <= modo_div;
      cnt   <= '0;
    end else if (step) begin
      acc <= acc_nx;
      sr  <= sr_nx;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multicycle ALU: single-cycle add/sub/logic, N-cycle mul/div,
// registered result, compare flags and status.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int LARGURA = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  input  logic [LARGURA-1:0]     A,
  input  logic [LARGURA-1:0]     B,
  input  logic [3:0]             Sel_Op,
  output logic [2*LARGURA-1:0]   Resultado,
  output logic                   Maior,
  output logic                   Menor,
  output logic                   Igual,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   div_zero,
  output logic                   op_invalida
);

  localparam int N = LARGURA;

  estado_t estado, prox;
  logic [N-1:0]   a_q, b_q, opa, opb;
  logic [3:0]     op_q, op;
  logic           ocioso, eh_div, b_zero, lento;
  logic           start, passo, done, carregar;
  logic           inv_nx;
  logic [2*N-1:0] res_nx, produto;
  logic [N-1:0]   quociente, resto;

  mult_div_iterativo #(.N(N)) u_md (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .step     (passo),
    .modo_div (eh_div),
    .a        (opa),
    .b        (opb),
    .done     (done),
    .produto  (produto),
    .quociente(quociente),
    .resto    (resto)
  );

  // Operands come straight from the ports in the start cycle,
  // from the latches while an iterative op is in flight.
  always_comb begin
    ocioso = (estado == OCIOSO);
    opa    = ocioso ? A : a_q;
    opb    = ocioso ? B : b_q;
    op     = ocioso ? Sel_Op : op_q;
    eh_div = (op == OP_QUO) || (op == OP_REM);
    b_zero = (opb == '0);
    lento  = (op == OP_MUL) || (eh_div && !b_zero);
    start  = ocioso && inicio && lento;
    passo  = (estado == CALC);
  end

  // Result selection for whichever operation completes this cycle.
  always_comb begin
    res_nx = '0;
    inv_nx = 1'b0;
    case (op)
      OP_ADD:  res_nx = {{N{1'b0}}, opa} + {{N{1'b0}}, opb};
      OP_SUB:  res_nx = {{N{1'b0}}, opa} - {{N{1'b0}}, opb};
      OP_MUL:  res_nx = produto;
      OP_QUO:  res_nx = b_zero ? {{N{1'b0}}, {N{1'b1}}}
                               : {{N{1'b0}}, quociente};
      OP_REM:  res_nx = b_zero ? {{N{1'b0}}, opa}
                               : {{N{1'b0}}, resto};
      OP_AND:  res_nx = {{N{1'b0}}, opa & opb};
      OP_OR:   res_nx = {{N{1'b0}}, opa | opb};
      OP_NAND: res_nx = {{N{1'b0}}, ~(opa & opb)};
      OP_NOR:  res_nx = {{N{1'b0}}, ~(opa | opb)};
      OP_XOR:  res_nx = {{N{1'b0}}, opa ^ opb};
      OP_NOT:  res_nx = {{N{1'b0}}, ~opa};
      default: inv_nx = 1'b1;
    endcase
  end

  // Next-state logic; inicio only matters while idle.
  always_comb begin
    prox     = estado;
    carregar = 1'b0;
    case (estado)
      OCIOSO: begin
        if (inicio) begin
          prox     = lento ? CALC : FIM;
          carregar = !lento;
        end
      end
      CALC: begin
        if (done) begin
          prox     = FIM;
          carregar = 1'b1;
        end
      end
      FIM:     prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  assign ocupado = (estado != OCIOSO);
  assign pronto  = (estado == FIM);

  // State, operand latches and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado      <= OCIOSO;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      Resultado   <= '0;
      Maior       <= 1'b0;
      Menor       <= 1'b0;
      Igual       <= 1'b0;
      div_zero    <= 1'b0;
      op_invalida <= 1'b0;
    end else begin
      estado <= prox;
      if (ocioso && inicio) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= Sel_Op;
      end
      if (carregar) begin
        Resultado   <= res_nx;
        Maior       <= opa > opb;
        Menor       <= opa < opb;
        Igual       <= opa == opb;
        div_zero    <= eh_div && b_zero;
        op_invalida <= inv_nx;
      end
    end
  end

endmodule
